// File: rtl/instr_feeder_if.sv
// Host/processor-facing signal bundle for instr_feeder: a host write port, the
// processor's din/fetch pair, and the level and sticky status flags.
interface instr_feeder_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              full;
  logic [LVL_W-1:0]  level;
  logic              fetch;
  logic [DATA_W-1:0] din;
  logic              valid;
  logic              overflow;
  logic              underflow;
  logic              clr_flags;

  // The feeder itself.
  modport slave (
    input  wr_en, wr_data, fetch, clr_flags,
    output full, level, din, valid, overflow, underflow
  );

  // The host loader and the processor together.
  modport master (
    output wr_en, wr_data, fetch, clr_flags,
    input  full, level, din, valid, overflow, underflow
  );
endinterface

// File: rtl/instr_feeder.sv
// First-word-fall-through instruction/data buffer feeding simple_proc.din.
// Optional build macro INSTR_FEEDER_NOP_FILL_EN drives NOP_WORD on din while empty.
module instr_feeder #(
  parameter int                 DATA_W   = 16,
  parameter int                 DEPTH    = 16,
  parameter logic [DATA_W-1:0]  NOP_WORD = '0
) (
  input logic            clk,
  input logic            rst,
  instr_feeder_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);

  typedef logic [PTR_W-1:0]  ptr_t;
  typedef logic [LVL_W-1:0]  lvl_t;
  typedef logic [DATA_W-1:0] word_t;

`ifdef INSTR_FEEDER_NOP_FILL_EN
  localparam word_t DIN_RST = NOP_WORD;
`else
  localparam word_t DIN_RST = '0;
`endif

  word_t mem_q [DEPTH];
  ptr_t  wr_ptr_q, wr_ptr_d;
  ptr_t  rd_ptr_q, rd_ptr_d;
  ptr_t  rd_next;
  lvl_t  level_q, level_d;
  word_t din_q, din_d;
  logic  overflow_q, overflow_d;
  logic  underflow_q, underflow_d;
  logic  full, valid, fetch_ok, wr_ok;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    full        = (level_q == lvl_t'(DEPTH));
    valid       = (level_q != '0);
    fetch_ok    = bus.fetch && valid;
    wr_ok       = bus.wr_en && (!full || fetch_ok);
    rd_next     = rd_ptr_q + ptr_t'(1);
    wr_ptr_d    = wr_ok    ? wr_ptr_q + ptr_t'(1) : wr_ptr_q;
    rd_ptr_d    = fetch_ok ? rd_next              : rd_ptr_q;
    level_d     = level_q;
    din_d       = din_q;

    unique case ({wr_ok, fetch_ok})
      2'b10:   level_d = level_q + lvl_t'(1);
      2'b01:   level_d = level_q - lvl_t'(1);
      default: level_d = level_q;
    endcase

    // The head register follows the word that will sit at rd_ptr after this edge.
    if (wr_ok && !valid) begin
      din_d = bus.wr_data;
    end else if (fetch_ok) begin
      if (level_q >= lvl_t'(2)) begin
        din_d = mem_q[rd_next];
      end else if (wr_ok) begin
        din_d = bus.wr_data;
      end else begin
`ifdef INSTR_FEEDER_NOP_FILL_EN
        din_d = NOP_WORD;
`else
        din_d = din_q;
`endif
      end
    end

    overflow_d  = (overflow_q && !bus.clr_flags) || (bus.wr_en && full && !fetch_ok);
`ifdef INSTR_FEEDER_NOP_FILL_EN
    underflow_d = 1'b0;
`else
    underflow_d = (underflow_q && !bus.clr_flags) || (bus.fetch && !valid);
`endif
  end

  // NOTE: the storage array has no reset; level and pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= bus.wr_data;
  end

  // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      din_q       <= DIN_RST;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      din_q       <= din_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.full      = full;
  assign bus.valid     = valid;
  assign bus.level     = level_q;
  assign bus.din       = din_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_instr_feeder.sv
// Directed self-checking bench for instr_feeder (DEPTH=16, DATA_W=16); honours
// INSTR_FEEDER_NOP_FILL_EN when computing empty-buffer expectations.
module tb_instr_feeder;
  localparam int          DATA_W = 16;
  localparam int          DEPTH  = 16;
  localparam logic [15:0] NOP    = 16'h0000;
`ifdef INSTR_FEEDER_NOP_FILL_EN
  localparam bit NOP_FILL = 1'b1;
`else
  localparam bit NOP_FILL = 1'b0;
`endif
  localparam logic [15:0] DIN_RST = NOP_FILL ? NOP : 16'h0000;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  logic [15:0] model [$];

  always #5 clk = ~clk;

  instr_feeder_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  instr_feeder #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NOP_WORD(NOP)) u_dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.wr_en     = 1'b0;
    bus.wr_data   = '0;
    bus.fetch     = 1'b0;
    bus.clr_flags = 1'b0;
    repeat (2) tick();
    check("rst_din",   bus.din,       DIN_RST);
    check("rst_valid", bus.valid,     0);
    check("rst_full",  bus.full,      0);
    check("rst_level", bus.level,     0);
    check("rst_ovf",   bus.overflow,  0);
    check("rst_unf",   bus.underflow, 0);
    #2 rst_n = 1'b1;
    tick();

    // Single word through an empty buffer.
    bus.wr_en = 1'b1; bus.wr_data = 16'h1234;
    tick();
    bus.wr_en = 1'b0;
    check("one_din",   bus.din,   16'h1234);
    check("one_valid", bus.valid, 1);
    check("one_level", bus.level, 1);
    bus.fetch = 1'b1;
    tick();
    bus.fetch = 1'b0;
    check("one_pop_valid", bus.valid, 0);
    check("one_pop_level", bus.level, 0);
    check("one_pop_din",   bus.din,   NOP_FILL ? NOP : 16'h1234);

    // Fill to full, then overrun.
    for (int i = 0; i < DEPTH; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 16'(i);
      model.push_back(16'(i));
      tick();
    end
    check("fill_full",  bus.full,  1);
    check("fill_level", bus.level, 16);
    check("fill_din",   bus.din,   16'h0000);
    bus.wr_data = 16'hBEEF;
    tick();
    bus.wr_en = 1'b0;
    check("ovr_flag",  bus.overflow, 1);
    check("ovr_level", bus.level,    16);
    check("ovr_full",  bus.full,     1);
    bus.clr_flags = 1'b1;
    tick();
    bus.clr_flags = 1'b0;
    check("ovr_clr", bus.overflow, 0);

    // Simultaneous write and pop at full, long enough to wrap the pointers.
    for (int i = 0; i < 40; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 16'(16'h00A0 + i);
      bus.fetch = 1'b1;
      model.push_back(16'(16'h00A0 + i));
      tick();
      void'(model.pop_front());
      check("wrap_din",   bus.din,   model[0]);
      check("wrap_level", bus.level, 16);
    end
    bus.wr_en = 1'b0;
    check("wrap_ovf", bus.overflow, 0);

    // Drain with fetch held high: one pop per cycle, in order.
    for (int i = 0; i < DEPTH; i++) begin
      check("drain_din", bus.din, model[0]);
      tick();
      void'(model.pop_front());
    end
    bus.fetch = 1'b0;
    check("drain_level", bus.level,     0);
    check("drain_valid", bus.valid,     0);
    check("drain_unf",   bus.underflow, 0);
    check("drain_din",   bus.din,       NOP_FILL ? NOP : 16'h00C7);

    // Pop and write together with a single word held.
    bus.wr_en = 1'b1; bus.wr_data = 16'h0001;
    tick();
    check("l1_din", bus.din, 16'h0001);
    bus.wr_data = 16'h0002; bus.fetch = 1'b1;
    tick();
    bus.wr_en = 1'b0;
    check("l1_swap_din",   bus.din,   16'h0002);
    check("l1_swap_level", bus.level, 1);
    check("l1_swap_valid", bus.valid, 1);
    tick();
    bus.fetch = 1'b0;
    check("l1_empty_level", bus.level, 0);
    check("l1_empty_din",   bus.din,   NOP_FILL ? NOP : 16'h0002);

    // Fetch while empty; set beats clear in the same cycle.
    bus.fetch = 1'b1;
    tick();
    check("unf_flag",  bus.underflow, NOP_FILL ? 0 : 1);
    check("unf_din",   bus.din,       NOP_FILL ? NOP : 16'h0002);
    check("unf_level", bus.level,     0);
    bus.clr_flags = 1'b1;
    tick();
    bus.fetch = 1'b0;
    check("unf_set_wins", bus.underflow, NOP_FILL ? 0 : 1);
    tick();
    bus.clr_flags = 1'b0;
    check("unf_clr", bus.underflow, 0);

    // Asynchronous reset with words buffered and traffic in flight.
    for (int i = 0; i < 5; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 16'(16'h0051 + i);
      tick();
    end
    check("pre_rst_level", bus.level, 5);
    check("pre_rst_din",   bus.din,   16'h0051);
    bus.wr_data = 16'hDEAD; bus.fetch = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    check("arst_level", bus.level,     0);
    check("arst_valid", bus.valid,     0);
    check("arst_full",  bus.full,      0);
    check("arst_din",   bus.din,       DIN_RST);
    check("arst_ovf",   bus.overflow,  0);
    check("arst_unf",   bus.underflow, 0);
    bus.wr_en = 1'b0; bus.fetch = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    bus.wr_en = 1'b1; bus.wr_data = 16'h0077;
    tick();
    bus.wr_en = 1'b0;
    check("post_rst_din",   bus.din,   16'h0077);
    check("post_rst_level", bus.level, 1);
    check("post_rst_valid", bus.valid, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
